// File: rtl/fifo_ctrl_if.sv
// Producer/consumer side of the FIFO controller: push/pop requests, read data and status.
// The controller takes the slave modport; the user logic driving requests takes master.
interface fifo_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic              push;
   logic [DATA_W-1:0] data_in;
   logic              pop;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output push, data_in, pop,
      input  data_out, valid_out, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  push, data_in, pop,
      output data_out, valid_out, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that turns an external synchronous dual-port RAM
// (write port A, read port B, read-before-write) into a FIFO.
module fifo_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int AF_TH  = 6,
   parameter int AE_TH  = 2
) (
   input  logic              clk,
   input  logic              reset_L,
   fifo_ctrl_if.slave        fif,
   output logic              we_a,
   output logic [ADDR_W-1:0] addr_a,
   output logic [DATA_W-1:0] data_a,
   output logic              re_b,
   output logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] q_b
);

   localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_TH);
   localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_TH);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_next;
   logic              valid_q;
   logic              overflow_q;
   logic              underflow_q;
   logic              full_w;
   logic              empty_w;
   logic              push_ok;
   logic              pop_ok;

   assign full_w  = (count_q == DEPTH);
   assign empty_w = (count_q == '0);

   // A push into a full FIFO rides on a simultaneous pop: the RAM reads the
   // oldest slot before the write lands in that same slot.
   assign push_ok = fif.push & (~full_w | fif.pop);
   assign pop_ok  = fif.pop & ~empty_w;

   assign we_a   = push_ok & reset_L;
   assign addr_a = wr_ptr;
   assign data_a = fif.data_in;
   assign re_b   = pop_ok & reset_L;
   assign addr_b = rd_ptr;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      count_next = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_next = count_q + (ADDR_W+1)'(1);
         2'b01:   count_next = count_q - (ADDR_W+1)'(1);
         default: count_next = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   // NOTE: reset clears pointers only; stale RAM contents become unreachable, so the RAM is never cleared.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
         count_q     <= count_next;
         valid_q     <= pop_ok;
         overflow_q  <= overflow_q  | (fif.push & full_w & ~fif.pop);
         underflow_q <= underflow_q | (fif.pop & empty_w);
      end
   end

   assign fif.data_out     = q_b;
   assign fif.valid_out    = valid_q;
   assign fif.count        = count_q;
   assign fif.full         = full_w;
   assign fif.empty        = empty_w;
   assign fif.almost_full  = (count_q >= AF_LVL);
   assign fif.almost_empty = (count_q <= AE_LVL);
   assign fif.overflow     = overflow_q;
   assign fif.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a behavioural read-before-write dual-port RAM.
// Read data is checked every negative edge against the queue of expected pops.
module tb_fifo_ctrl;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 8;
   localparam int AF_TH  = 6;
   localparam int AE_TH  = 2;

   logic              clk = 1'b0;
   logic              reset_L = 1'b0;
   logic              we_a, re_b;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic [DATA_W-1:0] data_a, q_b;
   logic [DATA_W-1:0] mem [DEPTH];

   int n_vec = 0;
   int n_err = 0;

   // reference model
   logic [DATA_W-1:0] contents[$];
   logic [DATA_W-1:0] sb[$];
   int   m_cnt = 0, m_wr = 0, m_rd = 0;
   logic m_pok = 1'b0, m_qok = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
   logic m_ovf_set = 1'b0, m_unf_set = 1'b0;

   fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fif ();

   fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .fif     (fif.slave),
      .we_a    (we_a),
      .addr_a  (addr_a),
      .data_a  (data_a),
      .re_b    (re_b),
      .addr_b  (addr_b),
      .q_b     (q_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (re_b) q_b <= mem[addr_b];
      if (we_a) mem[addr_a] <= data_a;
   end

   // every accepted pop must produce exactly one valid_out, in order, one cycle later
   always @(negedge clk) begin
      logic [DATA_W-1:0] exp_d;
      logic              exp_v;
      exp_v = (sb.size() != 0);
      exp_d = '0;
      if (exp_v) exp_d = sb.pop_front();
      n_vec++;
      if (fif.valid_out !== exp_v) begin
         n_err++;
         $display("FAIL valid_out: got %b, expected %b (t=%0t)", fif.valid_out, exp_v, $time);
      end else if (exp_v) begin
         n_vec++;
         if (fif.data_out !== exp_d) begin
            n_err++;
            $display("FAIL data_out: got %h, expected %h (t=%0t)", fif.data_out, exp_d, $time);
         end
      end
   end

   task automatic drive(input logic p, input logic [DATA_W-1:0] d, input logic q);
      @(negedge clk);
      fif.push = p;
      fif.data_in = d;
      fif.pop = q;
      m_pok = p && ((m_cnt != DEPTH) || q);
      m_qok = q && (m_cnt != 0);
      m_ovf_set = p && (m_cnt == DEPTH) && !q;
      m_unf_set = q && (m_cnt == 0);
      #1;
   endtask

   task automatic commit();
      @(posedge clk);
      if (m_qok) begin
         sb.push_back(contents.pop_front());
         m_rd = (m_rd + 1) % DEPTH;
      end
      if (m_pok) begin
         contents.push_back(fif.data_in);
         m_wr = (m_wr + 1) % DEPTH;
      end
      m_cnt = m_cnt + int'(m_pok) - int'(m_qok);
      m_ovf = m_ovf | m_ovf_set;
      m_unf = m_unf | m_unf_set;
      #1;
      fif.push = 1'b0;
      fif.pop = 1'b0;
   endtask

   task automatic step(input logic p, input logic [DATA_W-1:0] d, input logic q);
      drive(p, d, q);
      commit();
   endtask

   // one reset cycle with push and pop both requested; neither may reach the RAM
   task automatic do_reset();
      @(negedge clk);
      reset_L = 1'b0;
      fif.push = 1'b1;
      fif.pop = 1'b1;
      fif.data_in = 8'hEE;
      #1;
      n_vec++;
      if (we_a !== 1'b0 || re_b !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ram_enables: got we_a=%b re_b=%b, expected 0 0", we_a, re_b);
      end
      @(posedge clk);
      #1;
      fif.push = 1'b0;
      fif.pop = 1'b0;
      contents.delete();
      sb.delete();
      m_cnt = 0; m_wr = 0; m_rd = 0;
      m_pok = 1'b0; m_qok = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   task automatic test_reset();
      logic [8:0] got;
      do_reset();
      got = {fif.count, fif.empty, fif.full, fif.almost_empty, fif.almost_full, fif.overflow};
      n_vec++;
      if (got !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0} || fif.underflow !== 1'b0 || fif.valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got cnt/e/f/ae/af/ovf=%b unf=%b v=%b, expected 000010100 0 0",
                  got, fif.underflow, fif.valid_out);
      end
   endtask

   task automatic test_fill(input logic [DATA_W-1:0] base);
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, base + DATA_W'(i), 1'b0);
         n_vec++;
         if (we_a !== 1'b1 || addr_a !== ADDR_W'(m_wr)) begin
            n_err++;
            $display("FAIL fill_write[%0d]: got we_a=%b addr_a=%0d, expected 1 %0d", i, we_a, addr_a, m_wr);
         end
         commit();
         n_vec++;
         if (fif.count !== 4'(m_cnt) || fif.almost_full !== (m_cnt >= AF_TH) ||
             fif.full !== (m_cnt == DEPTH) || fif.almost_empty !== (m_cnt <= AE_TH) || fif.empty !== 1'b0) begin
            n_err++;
            $display("FAIL fill_flags[%0d]: got cnt=%0d af=%b f=%b ae=%b e=%b, expected cnt=%0d af=%b f=%b ae=%b e=0",
                     i, fif.count, fif.almost_full, fif.full, fif.almost_empty, fif.empty,
                     m_cnt, (m_cnt >= AF_TH), (m_cnt == DEPTH), (m_cnt <= AE_TH));
         end
      end
   endtask

   task automatic test_drain(input string tag);
      while (m_cnt != 0) begin
         drive(1'b0, '0, 1'b1);
         n_vec++;
         if (re_b !== 1'b1 || addr_b !== ADDR_W'(m_rd)) begin
            n_err++;
            $display("FAIL %s_read: got re_b=%b addr_b=%0d, expected 1 %0d", tag, re_b, addr_b, m_rd);
         end
         commit();
      end
      step(1'b0, '0, 1'b0);
      n_vec++;
      if (fif.empty !== 1'b1 || fif.count !== 4'd0 || fif.overflow !== m_ovf) begin
         n_err++;
         $display("FAIL %s_end: got e=%b cnt=%0d ovf=%b, expected 1 0 %b", tag, fif.empty, fif.count, fif.overflow, m_ovf);
      end
   endtask

   task automatic test_overflow_drain();
      drive(1'b1, 8'hAA, 1'b0);
      n_vec++;
      if (we_a !== 1'b0) begin
         n_err++;
         $display("FAIL overflow_we: got %b, expected 0", we_a);
      end
      commit();
      n_vec++;
      if (fif.overflow !== 1'b1 || fif.count !== 4'd8 || fif.full !== 1'b1) begin
         n_err++;
         $display("FAIL overflow_state: got ovf=%b cnt=%0d f=%b, expected 1 8 1", fif.overflow, fif.count, fif.full);
      end
      test_drain("ovf_drain");
   endtask

   task automatic test_underflow();
      do_reset();
      drive(1'b0, '0, 1'b1);
      n_vec++;
      if (re_b !== 1'b0) begin
         n_err++;
         $display("FAIL underflow_re: got %b, expected 0", re_b);
      end
      commit();
      n_vec++;
      if (fif.underflow !== 1'b1 || fif.count !== 4'd0) begin
         n_err++;
         $display("FAIL underflow_state: got unf=%b cnt=%0d, expected 1 0", fif.underflow, fif.count);
      end
      drive(1'b1, 8'h33, 1'b1);
      n_vec++;
      if (we_a !== 1'b1 || re_b !== 1'b0) begin
         n_err++;
         $display("FAIL empty_push_pop: got we_a=%b re_b=%b, expected 1 0", we_a, re_b);
      end
      commit();
      n_vec++;
      if (fif.count !== 4'd1 || fif.empty !== 1'b0) begin
         n_err++;
         $display("FAIL empty_push_pop_cnt: got cnt=%0d e=%b, expected 1 0", fif.count, fif.empty);
      end
      test_drain("unf_drain");
   endtask

   task automatic test_full_push_pop();
      do_reset();
      test_fill(8'h20);
      drive(1'b1, 8'h55, 1'b1);
      n_vec++;
      if (we_a !== 1'b1 || re_b !== 1'b1 || addr_a !== 3'd0 || addr_b !== 3'd0) begin
         n_err++;
         $display("FAIL full_push_pop_ram: got we=%b re=%b aa=%0d ab=%0d, expected 1 1 0 0", we_a, re_b, addr_a, addr_b);
      end
      commit();
      n_vec++;
      if (fif.count !== 4'd8 || fif.full !== 1'b1 || fif.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL full_push_pop_state: got cnt=%0d f=%b ovf=%b, expected 8 1 0", fif.count, fif.full, fif.overflow);
      end
      test_drain("fpp_drain");
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, DATA_W'(i * 37 + 11), 1'b0);
         step(1'b0, '0, 1'b1);
      end
      // a few overlapping pairs keep the read pointer one slot behind across the wrap
      step(1'b1, 8'hC0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, DATA_W'(8'hC1 + i), 1'b1);
      test_drain("wrap_drain");
      drive(1'b0, '0, 1'b0);
      n_vec++;
      if (addr_a !== ADDR_W'(m_wr) || addr_b !== ADDR_W'(m_rd) || m_wr != 3) begin
         n_err++;
         $display("FAIL wrap_ptrs: got addr_a=%0d addr_b=%0d, expected %0d %0d (model wr 3)", addr_a, addr_b, m_wr, m_rd);
      end
      commit();
   endtask

   task automatic test_mid_reset();
      do_reset();
      step(1'b0, '0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(8'h40 + i), 1'b0);
      n_vec++;
      if (fif.count !== 4'd5 || fif.underflow !== 1'b1) begin
         n_err++;
         $display("FAIL mid_pre: got cnt=%0d unf=%b, expected 5 1", fif.count, fif.underflow);
      end
      do_reset();
      n_vec++;
      if (fif.count !== 4'd0 || fif.empty !== 1'b1 || fif.valid_out !== 1'b0 ||
          fif.underflow !== 1'b0 || fif.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: got cnt=%0d e=%b v=%b unf=%b ovf=%b, expected 0 1 0 0 0",
                  fif.count, fif.empty, fif.valid_out, fif.underflow, fif.overflow);
      end
      drive(1'b1, 8'h99, 1'b0);
      n_vec++;
      if (addr_a !== 3'd0 || we_a !== 1'b1) begin
         n_err++;
         $display("FAIL mid_restart: got addr_a=%0d we_a=%b, expected 0 1", addr_a, we_a);
      end
      commit();
      test_drain("mid_drain");
   endtask

   initial begin
      fif.push = 1'b0;
      fif.pop = 1'b0;
      fif.data_in = '0;
      test_reset();
      test_fill(8'h10);
      test_overflow_drain();
      test_underflow();
      test_full_push_pop();
      test_wrap();
      test_mid_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
